keypad_scan: RTL and testbench

- 4x4 matrix keypad scanner for the player-input side of the game.
- Uses the same one-cold rotation scheme (1110, 1101, 1011, 0111) as the display digit driver, but drives keypad rows and reads keypad columns.
- Debounces each press and emits a single-cycle key event with a 4-bit key code, plus a held level.
- Sits between the board pins and the game logic; runs from the system clock with an internal scan divider.

---
 rtl/keypad_scan_if.sv | 26 ++
 rtl/keypad_scan.sv | 162 ++++++++++++++++
 tb/tb_keypad_scan.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_if.sv
// Pin-side and event-side signals of the 4x4 keypad scanner.
// The master end (the scanner) reads the columns and drives rows and key events.
// The slave end is the board/game side: it drives the columns and observes the rest.
interface keypad_scan_if;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  col,
    output row,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output col,
    input  row,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scan.sv
// Purpose: 4x4 keypad scanner, one-cold row rotation, debounced press/release, key event + held level.
// Latency: 2-clk column sync; press accepted DEBOUNCE_TICKS scan ticks after detection, +1 clk registered output.
// Backpressure: none; key_valid is a one-clk pulse the consumer must sample when it appears.
module keypad_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input logic          clk,
  input logic          rst_n,
  keypad_scan_if.master bus
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       col_m, col_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [DEB_W-1:0] deb_cnt, deb_cnt_nxt;
  logic [1:0]       row_idx, row_idx_nxt;
  logic [1:0]       col_idx, col_idx_nxt;
  logic [1:0]       first_low;
  logic             col_low;
  logic [3:0]       key_code, key_code_nxt;
  logic             key_valid, key_valid_nxt;
  logic             key_held, key_held_nxt;

  // Two-flop synchronizer for the asynchronous column inputs (idle level is all-high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
    end else begin
      col_m <= bus.col;
      col_s <= col_m;
    end
  end

  // Free-running scan divider; tick marks the last cycle of each row dwell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  // Lowest-index active-low column wins when several are down together.
  always_comb begin
    first_low = 2'd3;
    if (!col_s[0])      first_low = 2'd0;
    else if (!col_s[1]) first_low = 2'd1;
    else if (!col_s[2]) first_low = 2'd2;
  end

  assign col_low = ~col_s[col_idx];

  // State and output registers; outputs are registered so key_valid is a clean one-clk pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      deb_cnt   <= '0;
      row_idx   <= 2'd0;
      col_idx   <= 2'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nxt;
      deb_cnt   <= deb_cnt_nxt;
      row_idx   <= row_idx_nxt;
      col_idx   <= col_idx_nxt;
      key_code  <= key_code_nxt;
      key_valid <= key_valid_nxt;
      key_held  <= key_held_nxt;
    end
  end

  // Scan/debounce sequencing: every decision is taken only on a scan tick.
  always_comb begin
    state_nxt     = state;
    deb_cnt_nxt   = deb_cnt;
    row_idx_nxt   = row_idx;
    col_idx_nxt   = col_idx;
    key_code_nxt  = key_code;
    key_valid_nxt = 1'b0;
    key_held_nxt  = key_held;
    case (state)
      SCAN: begin
        if (tick) begin
          if (col_s == 4'hF) begin
            row_idx_nxt = row_idx + 2'd1;
          end else begin
            // Row stays put; row_idx already names the row being debounced.
            col_idx_nxt = first_low;
            deb_cnt_nxt = '0;
            state_nxt   = DEBOUNCE;
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (col_low) begin
            if (deb_cnt == DEB_LAST) begin
              state_nxt     = PRESSED;
              key_code_nxt  = {row_idx, col_idx};
              key_valid_nxt = 1'b1;
              key_held_nxt  = 1'b1;
            end else begin
              deb_cnt_nxt = deb_cnt + DEB_W'(1);
            end
          end else begin
            // Bounce: abandon silently and keep scanning without losing a dwell.
            state_nxt   = SCAN;
            row_idx_nxt = row_idx + 2'd1;
          end
        end
      end
      PRESSED: begin
        if (tick && !col_low) begin
          deb_cnt_nxt = '0;
          state_nxt   = RELEASE;
        end
      end
      RELEASE: begin
        if (tick) begin
          if (!col_low) begin
            if (deb_cnt == DEB_LAST) begin
              state_nxt    = SCAN;
              key_held_nxt = 1'b0;
            end else begin
              deb_cnt_nxt = deb_cnt + DEB_W'(1);
            end
          end else begin
            state_nxt = PRESSED;
          end
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

  assign bus.row       = ~(4'b0001 << row_idx);
  assign bus.key_code  = key_code;
  assign bus.key_valid = key_valid;
  assign bus.key_held  = key_held;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_TICKS=3.
// Each scenario task drives the columns and checks outputs #1 after clock edges.
module tb_keypad_scan;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int vld_cnt = 0;
  int consec = 0;
  logic prev_vld = 1'b0;

  keypad_scan_if bus();

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_TICKS(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  // Count key_valid pulses and back-to-back highs, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.key_valid === 1'b1) begin
      vld_cnt <= vld_cnt + 1;
      if (prev_vld === 1'b1) consec <= consec + 1;
    end
    prev_vld <= bus.key_valid;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_row_enter(input logic [3:0] target);
    bit left;
    bit ok;
    ok = 0;
    left = (bus.row !== target);
    for (int i = 0; i < 64; i++) begin
      step(1);
      if (!left) begin
        if (bus.row !== target) left = 1;
      end else if (bus.row === target) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL wait_row: row=%b never became %b", bus.row, target);
    end
  endtask

  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (bus.key_valid === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_held_low(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (bus.key_held === 1'b0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bus.col = 4'hF;
    rst_n = 1'b0;
    #12;
    checks++; if (bus.row !== 4'b1110) begin failures++; $display("FAIL reset_row: got %b want 1110", bus.row); end
    checks++; if (bus.key_code !== 4'd0) begin failures++; $display("FAIL reset_code: got %b want 0000", bus.key_code); end
    checks++; if (bus.key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", bus.key_valid); end
    checks++; if (bus.key_held !== 1'b0) begin failures++; $display("FAIL reset_held: got %b want 0", bus.key_held); end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_rotation;
    logic [3:0] exp_row [4];
    exp_row[0] = 4'b1101;
    exp_row[1] = 4'b1011;
    exp_row[2] = 4'b0111;
    exp_row[3] = 4'b1110;
    for (int k = 0; k < 4; k++) begin
      step(4);
      checks++;
      if (bus.row !== exp_row[k]) begin
        failures++;
        $display("FAIL idle_row%0d: got %b want %b", k, bus.row, exp_row[k]);
      end
    end
    checks++; if (vld_cnt != 0) begin failures++; $display("FAIL idle_valid: pulses=%0d want 0", vld_cnt); end
    checks++; if (bus.key_held !== 1'b0) begin failures++; $display("FAIL idle_held: got %b want 0", bus.key_held); end
  endtask

  task automatic test_press;
    int n;
    int base;
    base = vld_cnt;
    wait_row_enter(4'b1101);
    bus.col = 4'b1011;
    wait_valid(n);
    checks++; if (n != 16) begin failures++; $display("FAIL press_latency: got %0d clks want 16", n); end
    checks++; if (bus.key_code !== 4'b0110) begin failures++; $display("FAIL press_code: got %b want 0110", bus.key_code); end
    checks++; if (bus.key_held !== 1'b1) begin failures++; $display("FAIL press_held: got %b want 1", bus.key_held); end
    step(12);
    checks++; if (bus.row !== 4'b1101) begin failures++; $display("FAIL press_row_frozen: got %b want 1101", bus.row); end
    checks++; if (bus.key_held !== 1'b1) begin failures++; $display("FAIL press_held_hold: got %b want 1", bus.key_held); end
    checks++; if (vld_cnt != base + 1) begin failures++; $display("FAIL press_pulses: got %0d want %0d", vld_cnt, base + 1); end
  endtask

  task automatic test_release;
    int n;
    int base;
    base = vld_cnt;
    bus.col = 4'hF;
    wait_held_low(n);
    checks++; if (n != 16) begin failures++; $display("FAIL release_latency: got %0d clks want 16", n); end
    checks++; if (bus.row !== 4'b1101) begin failures++; $display("FAIL release_row_hold: got %b want 1101", bus.row); end
    step(4);
    checks++; if (bus.row !== 4'b1011) begin failures++; $display("FAIL release_resume: got %b want 1011", bus.row); end
    checks++; if (bus.key_code !== 4'b0110) begin failures++; $display("FAIL release_code_kept: got %b want 0110", bus.key_code); end
    checks++; if (vld_cnt != base) begin failures++; $display("FAIL release_pulses: got %0d want %0d", vld_cnt, base); end
  endtask

  task automatic test_bounce;
    int base;
    base = vld_cnt;
    bus.col = 4'b1110;
    step(4);
    checks++; if (bus.row !== 4'b1011) begin failures++; $display("FAIL bounce_detect_row: got %b want 1011", bus.row); end
    bus.col = 4'hF;
    step(4);
    checks++; if (bus.row !== 4'b0111) begin failures++; $display("FAIL bounce_rotate: got %b want 0111", bus.row); end
    checks++; if (bus.key_held !== 1'b0) begin failures++; $display("FAIL bounce_held: got %b want 0", bus.key_held); end
    checks++; if (vld_cnt != base) begin failures++; $display("FAIL bounce_pulses: got %0d want %0d", vld_cnt, base); end
  endtask

  task automatic test_release_glitch;
    int n;
    int base;
    base = vld_cnt;
    bus.col = 4'b1110;
    wait_valid(n);
    checks++; if (n != 16) begin failures++; $display("FAIL glitch_latency: got %0d clks want 16", n); end
    checks++; if (bus.key_code !== 4'b1100) begin failures++; $display("FAIL glitch_code: got %b want 1100", bus.key_code); end
    bus.col = 4'hF;
    step(4);
    checks++; if (bus.key_held !== 1'b1) begin failures++; $display("FAIL glitch_held_up: got %b want 1", bus.key_held); end
    bus.col = 4'b1110;
    step(4);
    checks++; if (bus.key_held !== 1'b1) begin failures++; $display("FAIL glitch_held_back: got %b want 1", bus.key_held); end
    step(8);
    checks++; if (bus.key_held !== 1'b1) begin failures++; $display("FAIL glitch_held_later: got %b want 1", bus.key_held); end
    checks++; if (vld_cnt != base + 1) begin failures++; $display("FAIL glitch_pulses: got %0d want %0d", vld_cnt, base + 1); end
    bus.col = 4'hF;
    wait_held_low(n);
    checks++; if (n != 16) begin failures++; $display("FAIL glitch_release: got %0d clks want 16", n); end
  endtask

  task automatic test_priority_and_reset;
    int n;
    int base;
    wait_row_enter(4'b0111);
    bus.col = 4'b0101;
    wait_valid(n);
    checks++; if (n != 16) begin failures++; $display("FAIL prio_latency: got %0d clks want 16", n); end
    checks++; if (bus.key_code !== 4'b1101) begin failures++; $display("FAIL prio_code: got %b want 1101", bus.key_code); end
    bus.col = 4'hF;
    wait_held_low(n);
    checks++; if (n != 16) begin failures++; $display("FAIL prio_release: got %0d clks want 16", n); end
    base = vld_cnt;
    bus.col = 4'b1110;
    step(6);
    checks++; if (bus.row !== 4'b0111) begin failures++; $display("FAIL rst_pre_row: got %b want 0111", bus.row); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.row !== 4'b1110) begin failures++; $display("FAIL rst_mid_row: got %b want 1110", bus.row); end
    checks++; if (bus.key_code !== 4'd0) begin failures++; $display("FAIL rst_mid_code: got %b want 0000", bus.key_code); end
    checks++; if (bus.key_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid: got %b want 0", bus.key_valid); end
    checks++; if (bus.key_held !== 1'b0) begin failures++; $display("FAIL rst_mid_held: got %b want 0", bus.key_held); end
    bus.col = 4'hF;
    step(2);
    rst_n = 1'b1;
    step(40);
    checks++; if (vld_cnt != base) begin failures++; $display("FAIL rst_after_pulses: got %0d want %0d", vld_cnt, base); end
    checks++; if (bus.key_held !== 1'b0) begin failures++; $display("FAIL rst_after_held: got %b want 0", bus.key_held); end
    checks++; if (consec != 0) begin failures++; $display("FAIL valid_consecutive: got %0d want 0", consec); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_rotation();
    test_press();
    test_release();
    test_bounce();
    test_release_glitch();
    test_priority_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
